// File: rtl/fsm_step_conditioner.sv
// Purpose : conditions the raw x switch and the bouncy step push-button for the
//           eight-state FSM. It syncs both inputs, debounces the button and
//           issues one single-cycle step_en per clean press. x is captured only
//           on a step, so it stays stable between steps.
// Latency : 2-flop synchroniser, then DEBOUNCE_CYCLES stable samples. A raw
//           press first sampled at edge e0 gives step_en high after edge
//           e0+DEBOUNCE_CYCLES+2.
// Backpressure: none. step_en is a fire-and-forget enable that the FSM uses as
//           its state-register enable.
//
// Ports:
//   clk        in   1  single clock, all logic on posedge
//   reset      in   1  synchronous, active-low reset
//   sw_x       in   1  raw asynchronous switch (FSM input value)
//   btn_step   in   1  raw asynchronous push-button, bouncy
//   x          out  1  x value captured on each step
//   step_en    out  1  one-cycle advance pulse
//   step_count out  8  number of step_en pulses issued, wraps 255->0
//   db_state   out  2  debounce state (IDLE=0, ARMING=1, HELD=2, RELEASING=3)
//
// Optional feature macro: AUTO_STEP_EN. When it is defined, a button held in
// HELD re-issues a step every REPEAT_CYCLES cycles.

module fsm_step_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw_x,
   input  logic       btn_step,
   output logic       x,
   output logic       step_en,
   output logic [7:0] step_count,
   output logic [1:0] db_state
);

   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_STEP_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      RELEASING = 2'd3
   } db_state_t;

   // Two-flop synchronisers.
   logic sx_meta, sx;
   logic sb_meta, sb;

   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             step;
`ifdef AUTO_STEP_EN
   logic [CNT_W-1:0] rcnt, rcnt_nxt;
`endif

   // Debounce next-state logic. cnt counts the stable samples seen so far,
   // and the same counter is reused for press and for release.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step      = 1'b0;
`ifdef AUTO_STEP_EN
      // The repeat counter runs only while the button stays held. Its default
      // is zero, so it clears on every entry into HELD, including the
      // RELEASING->HELD path.
      rcnt_nxt  = '0;
`endif
      case (state)
         IDLE: begin
            if (sb) begin
               state_nxt = ARMING;
               cnt_nxt   = '0;
            end
         end
         ARMING: begin
            if (!sb) begin
               state_nxt = IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt = HELD;
               step      = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!sb) begin
               state_nxt = RELEASING;
               cnt_nxt   = '0;
            end
`ifdef AUTO_STEP_EN
            else if (rcnt == RPT_LAST) begin
               step     = 1'b1;
               rcnt_nxt = '0;
            end else begin
               rcnt_nxt = rcnt + CNT_W'(1);
            end
`endif
         end
         RELEASING: begin
            // A bounce back high returns to HELD without a second step.
            if (sb) begin
               state_nxt = HELD;
            end else if (cnt == DB_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sx_meta    <= 1'b0;
         sx         <= 1'b0;
         sb_meta    <= 1'b0;
         sb         <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         x          <= 1'b0;
         step_en    <= 1'b0;
         step_count <= 8'd0;
`ifdef AUTO_STEP_EN
         rcnt       <= '0;
`endif
      end else begin
         sx_meta <= sw_x;
         sx      <= sx_meta;
         sb_meta <= btn_step;
         sb      <= sb_meta;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         step_en <= step;
`ifdef AUTO_STEP_EN
         rcnt    <= rcnt_nxt;
`endif
         // x is captured only with a step, so switch activity between steps
         // never reaches the FSM.
         if (step) begin
            x          <= sx;
            step_count <= step_count + 8'd1;
         end
      end
   end

   assign db_state = state;

endmodule

// File: tb/tb_fsm_step_conditioner.sv
// Purpose : directed bench for fsm_step_conditioner with DEBOUNCE_CYCLES=4 and
//           REPEAT_CYCLES=8. The expected values are hand-computed edge indices.
// Edge numbering: the first posedge that samples the raw button high is e0.
//           Outputs are sampled 1 time unit after each posedge.

module tb_fsm_step_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       sw_x;
   logic       btn_step;
   logic       x;
   logic       step_en;
   logic [7:0] step_count;
   logic [1:0] db_state;

   int checks = 0;
   int errors = 0;
   int ecount = 0;
   int pulses[$];
   logic prev_step = 1'b0;
   int total;

   fsm_step_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_x      (sw_x),
      .btn_step  (btn_step),
      .x         (x),
      .step_en   (step_en),
      .step_count(step_count),
      .db_state  (db_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge, then log any step pulse by edge index.
   task automatic cycle();
      @(posedge clk);
      #1;
      ecount++;
      if (step_en === 1'b1) begin
         pulses.push_back(ecount);
         check("step_en_not_back_to_back", 32'(prev_step), 0);
      end
      prev_step = step_en;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // The next edge after this call is e0.
   task automatic start_press();
      pulses.delete();
      ecount   = -1;
      btn_step = 1'b1;
   endtask

   task automatic press(input int high, input int low);
      start_press();
      run(high);
      btn_step = 1'b0;
      run(low);
   endtask

   function automatic int pulse_at(input int i);
      return (pulses.size() > i) ? pulses[i] : -1;
   endfunction

   initial begin
      // ---- reset with the button and the switch high ----
      reset    = 1'b0;
      btn_step = 1'b1;
      sw_x     = 1'b1;
      run(2);
      check("rst_x", 32'(x), 0);
      check("rst_step_en", 32'(step_en), 0);
      check("rst_step_count", 32'(step_count), 0);
      check("rst_db_state", 32'(db_state), 0);
      btn_step = 1'b0;
      run(1);
      reset = 1'b1;
      run(3);
      check("post_rst_idle", 32'(db_state), 0);

      // ---- bounce: high 3, low 1, high 3, low ----
      start_press();
      run(3);
      check("bounce_arming", 32'(db_state), 1);
      btn_step = 1'b0;
      run(1);
      btn_step = 1'b1;
      run(3);
      btn_step = 1'b0;
      run(10);
      check("bounce_no_pulse", pulses.size(), 0);
      check("bounce_count", 32'(step_count), 0);
      check("bounce_idle", 32'(db_state), 0);

      // ---- clean press, held for 20 cycles ----
      start_press();
      run(6);
      check("clean_x_before", 32'(x), 0);
      check("clean_no_early_step", 32'(step_en), 0);
      run(1);
      check("clean_step_e6", 32'(step_en), 1);
      check("clean_x_e6", 32'(x), 1);
      check("clean_count_e6", 32'(step_count), 1);
      run(4);
      check("clean_held", 32'(db_state), 2);
      check("clean_single", 32'(step_en), 0);
      run(9);
      btn_step = 1'b0;
      run(12);
`ifdef AUTO_STEP_EN
      check("clean_pulses", pulses.size(), 2);
      check("clean_count", 32'(step_count), 2);
`else
      check("clean_pulses", pulses.size(), 1);
      check("clean_count", 32'(step_count), 1);
`endif
      check("clean_first_edge", pulse_at(0), 6);
      check("clean_released", 32'(db_state), 0);

      // ---- x hold: the switch toggles between steps and during a press ----
      total = int'(step_count);
      repeat (6) begin
         sw_x = ~sw_x;
         cycle();
      end
      check("x_idle_hold", 32'(x), 1);
      // Press 1: sw_x = k%2 at edge k. The step at e6 captures the value
      // sampled at e4, which is 0.
      pulses.delete();
      ecount   = -1;
      btn_step = 1'b1;
      for (int k = 0; k < 22; k++) begin
         sw_x = logic'(k % 2);
         if (k == 10) btn_step = 1'b0;
         cycle();
         if (k == 5)  check("xh1_before", 32'(x), 1);
         if (k == 6)  check("xh1_at_step", 32'(x), 0);
         if (k == 21) check("xh1_after", 32'(x), 0);
      end
      check("xh1_pulse_edge", pulse_at(0), 6);
      // Press 2: inverted pattern, so the value sampled at e4 is 1.
      pulses.delete();
      ecount   = -1;
      btn_step = 1'b1;
      for (int k = 0; k < 22; k++) begin
         sw_x = logic'(1 - (k % 2));
         if (k == 10) btn_step = 1'b0;
         cycle();
         if (k == 5)  check("xh2_before", 32'(x), 0);
         if (k == 6)  check("xh2_at_step", 32'(x), 1);
         if (k == 21) check("xh2_after", 32'(x), 1);
      end
      check("xh_count", 32'(step_count), 32'((total + 2) % 256));

      // ---- wrap: 256 presses from a fresh reset ----
      sw_x  = 1'b1;
      reset = 1'b0;
      run(2);
      reset = 1'b1;
      run(2);
      check("wrap_start", 32'(step_count), 0);
      total = 0;
      for (int i = 0; i < 256; i++) begin
         press(8, 8);
         total += pulses.size();
         if (i == 254) check("wrap_255", 32'(step_count), 255);
      end
      check("wrap_pulses", total, 256);
      check("wrap_zero", 32'(step_count), 0);

      // ---- reset asserted while in HELD ----
      start_press();
      run(10);
      check("mid_held", 32'(db_state), 2);
      check("mid_x", 32'(x), 1);
      check("mid_count", 32'(step_count), 1);
      reset = 1'b0;
      run(2);
      check("mid_rst_x", 32'(x), 0);
      check("mid_rst_step_en", 32'(step_en), 0);
      check("mid_rst_count", 32'(step_count), 0);
      check("mid_rst_db_state", 32'(db_state), 0);
      btn_step = 1'b0;
      run(1);
      reset = 1'b1;
      pulses.delete();
      run(20);
      check("mid_no_release_pulse", pulses.size(), 0);
      check("mid_count_after", 32'(step_count), 0);

      // ---- button held 30 cycles ----
      start_press();
      run(30);
      btn_step = 1'b0;
      run(15);
`ifdef AUTO_STEP_EN
      check("hold_pulses", pulses.size(), 4);
      check("hold_e6", pulse_at(0), 6);
      check("hold_e14", pulse_at(1), 14);
      check("hold_e22", pulse_at(2), 22);
      check("hold_e30", pulse_at(3), 30);
      check("hold_count", 32'(step_count), 4);
`else
      check("hold_pulses", pulses.size(), 1);
      check("hold_e6", pulse_at(0), 6);
      check("hold_count", 32'(step_count), 1);
`endif
      check("hold_idle", 32'(db_state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
